// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: groups the decode inputs, memory handshake and datapath controls of the sequencer.
// Latency: none, wiring only.
// Backpressure: mem_ready_i is the only stall input; the controller holds its requests until it is seen.
interface multicycle_ctrl_if;
    logic [5:0]  opcode_i;
    logic [5:0]  funct_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        pc_write_o;
    logic        ir_write_o;
    logic        i_or_d_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        mem_to_reg_o;
    logic [1:0]  reg_dst_o;
    logic        reg_write_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [2:0]  alu_op_o;
    logic [1:0]  pc_source_o;
    logic        instr_done_o;
    logic        illegal_o;
    logic [3:0]  state_o;
    logic [31:0] cyc_cnt_o;
    logic [31:0] instr_cnt_o;
    logic [31:0] wait_cnt_o;

    modport master (
        output opcode_i, funct_i, zero_i, mem_ready_i,
        input  pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, mem_to_reg_o,
               reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o,
               instr_done_o, illegal_o, state_o, cyc_cnt_o, instr_cnt_o, wait_cnt_o
    );

    modport slave (
        input  opcode_i, funct_i, zero_i, mem_ready_i,
        output pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, mem_to_reg_o,
               reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o,
               instr_done_o, illegal_o, state_o, cyc_cnt_o, instr_cnt_o, wait_cnt_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control sequencer; perf counters exist only when MULTICYCLE_CTRL_PERF_EN is defined.
// Latency: 3 (beq/bne/j/jal/jr), 4 (R-type/addi/slti/sw) or 5 (lw) cycles with memory ready.
// Backpressure: FETCH, MEM_RD and MEM_WR hold their requests steady and add one cycle per mem_ready_i=0.
module multicycle_ctrl (
    input  logic             clk_i,
    input  logic             rst_i,
    multicycle_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_JR       = 4'd12,
        S_JAL      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_SLT   = 3'd3;

    state_t      state_q, state_d;
    logic        illegal_q;
    logic        set_illegal;
    logic        pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic [1:0]  reg_dst;
    logic        reg_write, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [1:0]  pc_source;
    logic        instr_done;
    logic        mem_wait;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | set_illegal;
        end
    end

    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 2'd0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        alu_op      = ALU_ADD;
        pc_source   = 2'd0;
        instr_done  = 1'b0;
        mem_wait    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                pc_write  = bus.mem_ready_i;
                ir_write  = bus.mem_ready_i;
                mem_wait  = ~bus.mem_ready_i;
                if (bus.mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target lands in ALUOut here; jal relies on the PC+4 from FETCH being kept.
                alu_src_b = 2'd3;
                case (bus.opcode_i)
                    OP_RTYPE:      state_d = (bus.funct_i == FN_JR) ? S_JR : S_R_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_JAL:        state_d = S_JAL;
                    OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
                    default: begin
                        state_d     = S_FETCH;
                        set_illegal = 1'b1;
                        instr_done  = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (bus.opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                mem_wait = ~bus.mem_ready_i;
                if (bus.mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                mem_wait   = ~bus.mem_ready_i;
                instr_done = bus.mem_ready_i;
                if (bus.mem_ready_i) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_dst    = 2'd1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_source  = 2'd1;
                pc_write   = (bus.opcode_i == OP_BNE) ? ~bus.zero_i : bus.zero_i;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = 2'd2;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = (bus.opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JR: begin
                alu_src_a  = 1'b1;
                pc_source  = 2'd3;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                reg_dst    = 2'd2;
                reg_write  = 1'b1;
                pc_source  = 2'd2;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset silences every control line regardless of the state still held in the register.
        if (rst_i) begin
            set_illegal = 1'b0;
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            i_or_d      = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            mem_to_reg  = 1'b0;
            reg_dst     = 2'd0;
            reg_write   = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'd0;
            alu_op      = ALU_ADD;
            pc_source   = 2'd0;
            instr_done  = 1'b0;
            mem_wait    = 1'b0;
        end
    end

    assign bus.pc_write_o   = pc_write;
    assign bus.ir_write_o   = ir_write;
    assign bus.i_or_d_o     = i_or_d;
    assign bus.mem_read_o   = mem_read;
    assign bus.mem_write_o  = mem_write;
    assign bus.mem_to_reg_o = mem_to_reg;
    assign bus.reg_dst_o    = reg_dst;
    assign bus.reg_write_o  = reg_write;
    assign bus.alu_src_a_o  = alu_src_a;
    assign bus.alu_src_b_o  = alu_src_b;
    assign bus.alu_op_o     = alu_op;
    assign bus.pc_source_o  = pc_source;
    assign bus.instr_done_o = instr_done;
    assign bus.illegal_o    = illegal_q;
    assign bus.state_o      = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cyc_cnt_q, instr_cnt_q, wait_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_cnt_q   <= 32'd0;
            instr_cnt_q <= 32'd0;
            wait_cnt_q  <= 32'd0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
            if (mem_wait)   wait_cnt_q  <= wait_cnt_q + 32'd1;
        end
    end

    assign bus.cyc_cnt_o   = cyc_cnt_q;
    assign bus.instr_cnt_o = instr_cnt_q;
    assign bus.wait_cnt_o  = wait_cnt_q;
`else
    logic unused_mem_wait;
    assign unused_mem_wait = mem_wait;
    assign bus.cyc_cnt_o   = 32'd0;
    assign bus.instr_cnt_o = 32'd0;
    assign bus.wait_cnt_o  = 32'd0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-instruction vectors against hand-derived control words for every state.
module tb_multicycle_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control word: pcw irw iod mr mw m2r rdst[2] rw asa asb[2] aop[3] psrc[2] done
    function automatic logic [17:0] cw(input int pcw, input int irw, input int iod, input int mr,
                                       input int mw, input int m2r, input int rdst, input int rw,
                                       input int asa, input int asb, input int aop, input int psrc,
                                       input int done);
        return {pcw[0], irw[0], iod[0], mr[0], mw[0], m2r[0], rdst[1:0], rw[0], asa[0],
                asb[1:0], aop[2:0], psrc[1:0], done[0]};
    endfunction

    function automatic logic [17:0] obs();
        return {bus.pc_write_o, bus.ir_write_o, bus.i_or_d_o, bus.mem_read_o, bus.mem_write_o,
                bus.mem_to_reg_o, bus.reg_dst_o, bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o,
                bus.alu_op_o, bus.pc_source_o, bus.instr_done_o};
    endfunction

    localparam logic [17:0] E_FETCH   = cw(1,1,0,1,0,0,0,0,0,1,0,0,0);
    localparam logic [17:0] E_FETCH_W = cw(0,0,0,1,0,0,0,0,0,1,0,0,0);
    localparam logic [17:0] E_DECODE  = cw(0,0,0,0,0,0,0,0,0,3,0,0,0);
    localparam logic [17:0] E_DEC_ILL = cw(0,0,0,0,0,0,0,0,0,3,0,0,1);
    localparam logic [17:0] E_MADDR   = cw(0,0,0,0,0,0,0,0,1,2,0,0,0);
    localparam logic [17:0] E_MRD     = cw(0,0,1,1,0,0,0,0,0,0,0,0,0);
    localparam logic [17:0] E_MWB     = cw(0,0,0,0,0,1,0,1,0,0,0,0,1);
    localparam logic [17:0] E_MWR     = cw(0,0,1,0,1,0,0,0,0,0,0,0,1);
    localparam logic [17:0] E_MWR_W   = cw(0,0,1,0,1,0,0,0,0,0,0,0,0);
    localparam logic [17:0] E_REXEC   = cw(0,0,0,0,0,0,0,0,1,0,2,0,0);
    localparam logic [17:0] E_RWB     = cw(0,0,0,0,0,0,1,1,0,0,0,0,1);
    localparam logic [17:0] E_BR_T    = cw(1,0,0,0,0,0,0,0,1,0,1,1,1);
    localparam logic [17:0] E_BR_N    = cw(0,0,0,0,0,0,0,0,1,0,1,1,1);
    localparam logic [17:0] E_JUMP    = cw(1,0,0,0,0,0,0,0,0,0,0,2,1);
    localparam logic [17:0] E_IEXEC_A = cw(0,0,0,0,0,0,0,0,1,2,0,0,0);
    localparam logic [17:0] E_IEXEC_S = cw(0,0,0,0,0,0,0,0,1,2,3,0,0);
    localparam logic [17:0] E_IWB     = cw(0,0,0,0,0,0,0,1,0,0,0,0,1);
    localparam logic [17:0] E_JR      = cw(1,0,0,0,0,0,0,0,1,0,0,3,1);
    localparam logic [17:0] E_JAL     = cw(1,0,0,0,0,0,2,1,0,0,0,2,1);

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode_i = 6'h00; bus.funct_i = 6'h00; bus.zero_i = 1'b0; bus.mem_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs() !== 18'd0) begin errors++; $display("FAIL reset_ctrl: got %05h want 00000", obs()); end
        checks++;
        if (bus.state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
        checks++;
        if (bus.illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", bus.illegal_o); end
        checks++;
        if ({bus.cyc_cnt_o, bus.instr_cnt_o, bus.wait_cnt_o} !== 96'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0",
                               bus.cyc_cnt_o, bus.instr_cnt_o, bus.wait_cnt_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [17:0] ex [4] = '{E_FETCH, E_DECODE, E_REXEC, E_RWB};
        int done_cnt = 0;
        bus.opcode_i = 6'h00; bus.funct_i = 6'h20; bus.mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.state_o, obs()} !== {st[i], ex[i]}) begin
                errors++; $display("FAIL rtype cyc%0d: got st=%0d ctrl=%05h want st=%0d ctrl=%05h",
                                   i, bus.state_o, obs(), st[i], ex[i]);
            end
            if (bus.instr_done_o === 1'b1) done_cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL rtype_done_pulses: got %0d want 1", done_cnt); end
        checks++;
        if (bus.state_o !== 4'd0) begin errors++; $display("FAIL rtype_return: got %0d want 0", bus.state_o); end
    endtask

    task automatic test_lw_wait();
        logic [3:0]  st  [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [17:0] ex  [7] = '{E_FETCH, E_DECODE, E_MADDR, E_MRD, E_MRD, E_MRD, E_MWB};
        logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] c0, n0, w0;
        logic [95:0] want;
        bus.opcode_i = 6'h23; bus.funct_i = 6'h00;
        c0 = bus.cyc_cnt_o; n0 = bus.instr_cnt_o; w0 = bus.wait_cnt_o;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready_i = rdy[i];
            @(negedge clk);
            checks++;
            if ({bus.state_o, obs()} !== {st[i], ex[i]}) begin
                errors++; $display("FAIL lw_wait cyc%0d: got st=%0d ctrl=%05h want st=%0d ctrl=%05h",
                                   i, bus.state_o, obs(), st[i], ex[i]);
            end
            @(posedge clk); #1;
        end
        bus.mem_ready_i = 1'b1;
`ifdef MULTICYCLE_CTRL_PERF_EN
        want = {32'd7, 32'd1, 32'd2};
`else
        want = 96'd0;
`endif
        checks++;
        if ({bus.cyc_cnt_o - c0, bus.instr_cnt_o - n0, bus.wait_cnt_o - w0} !== want) begin
            errors++; $display("FAIL lw_counters: got cyc+%0d instr+%0d wait+%0d want %0d/%0d/%0d",
                               bus.cyc_cnt_o - c0, bus.instr_cnt_o - n0, bus.wait_cnt_o - w0,
                               want[95:64], want[63:32], want[31:0]);
        end
    endtask

    task automatic test_branch();
        logic [5:0]  op [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
        logic        z  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [17:0] eb [4] = '{E_BR_T, E_BR_N, E_BR_N, E_BR_T};
        logic [17:0] ex [3];
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd8};
        for (int k = 0; k < 4; k++) begin
            bus.opcode_i = op[k]; bus.zero_i = z[k];
            ex = '{E_FETCH, E_DECODE, eb[k]};
            for (int i = 0; i < 3; i++) begin
                bus.mem_ready_i = (i == 0);
                @(negedge clk);
                checks++;
                if ({bus.state_o, obs()} !== {st[i], ex[i]}) begin
                    errors++; $display("FAIL branch%0d cyc%0d: got st=%0d ctrl=%05h want st=%0d ctrl=%05h",
                                       k, i, bus.state_o, obs(), st[i], ex[i]);
                end
                @(posedge clk); #1;
            end
        end
        bus.zero_i = 1'b0; bus.mem_ready_i = 1'b1;
    endtask

    task automatic test_jumps();
        logic [5:0]  op [3] = '{6'h03, 6'h00, 6'h02};
        logic [3:0]  sj [3] = '{4'd13, 4'd12, 4'd9};
        logic [17:0] ej [3] = '{E_JAL, E_JR, E_JUMP};
        logic [17:0] ex [3];
        logic [3:0]  st [3];
        bus.funct_i = 6'h08;
        for (int k = 0; k < 3; k++) begin
            bus.opcode_i = op[k];
            ex = '{E_FETCH, E_DECODE, ej[k]};
            st = '{4'd0, 4'd1, sj[k]};
            for (int i = 0; i < 3; i++) begin
                bus.mem_ready_i = (i == 0);
                @(negedge clk);
                checks++;
                if ({bus.state_o, obs()} !== {st[i], ex[i]}) begin
                    errors++; $display("FAIL jump%0d cyc%0d: got st=%0d ctrl=%05h want st=%0d ctrl=%05h",
                                       k, i, bus.state_o, obs(), st[i], ex[i]);
                end
                @(posedge clk); #1;
            end
        end
        bus.mem_ready_i = 1'b1; bus.funct_i = 6'h00;
    endtask

    task automatic test_back_to_back();
        logic [5:0]  op  [14] = '{6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B,
                                  6'h08, 6'h08, 6'h08, 6'h08, 6'h0A, 6'h0A, 6'h0A, 6'h0A};
        logic        rdy [14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0]  st  [14] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5,
                                  4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd1, 4'd10, 4'd11};
        logic [17:0] ex  [14] = '{E_FETCH_W, E_FETCH, E_DECODE, E_MADDR, E_MWR_W, E_MWR,
                                  E_FETCH, E_DECODE, E_IEXEC_A, E_IWB,
                                  E_FETCH, E_DECODE, E_IEXEC_S, E_IWB};
        for (int i = 0; i < 14; i++) begin
            bus.opcode_i = op[i]; bus.mem_ready_i = rdy[i];
            @(negedge clk);
            checks++;
            if ({bus.state_o, obs()} !== {st[i], ex[i]}) begin
                errors++; $display("FAIL b2b cyc%0d: got st=%0d ctrl=%05h want st=%0d ctrl=%05h",
                                   i, bus.state_o, obs(), st[i], ex[i]);
            end
            @(posedge clk); #1;
        end
        bus.mem_ready_i = 1'b1;
    endtask

    task automatic test_illegal();
        logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd6, 4'd7};
        logic [17:0] ex [6] = '{E_FETCH, E_DEC_ILL, E_FETCH, E_DECODE, E_REXEC, E_RWB};
        logic [5:0]  op [6] = '{6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00};
        checks++;
        if (bus.illegal_o !== 1'b0) begin errors++; $display("FAIL illegal_before: got %b want 0", bus.illegal_o); end
        bus.funct_i = 6'h22; bus.mem_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.opcode_i = op[i];
            @(negedge clk);
            checks++;
            if ({bus.state_o, obs()} !== {st[i], ex[i]}) begin
                errors++; $display("FAIL illegal cyc%0d: got st=%0d ctrl=%05h want st=%0d ctrl=%05h",
                                   i, bus.state_o, obs(), st[i], ex[i]);
            end
            @(posedge clk); #1;
            if (i == 1) begin
                checks++;
                if (bus.illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b want 1", bus.illegal_o); end
            end
        end
        checks++;
        if (bus.illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", bus.illegal_o); end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [17:0] ex [4] = '{E_FETCH, E_DECODE, E_MADDR, E_MRD};
        logic        rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.opcode_i = 6'h23;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready_i = rdy[i];
            @(negedge clk);
            checks++;
            if ({bus.state_o, obs()} !== {st[i], ex[i]}) begin
                errors++; $display("FAIL rstmid cyc%0d: got st=%0d ctrl=%05h want st=%0d ctrl=%05h",
                                   i, bus.state_o, obs(), st[i], ex[i]);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.state_o, obs()} !== {4'd3, 18'd0}) begin
            errors++; $display("FAIL rstmid_forced: got st=%0d ctrl=%05h want st=3 ctrl=00000", bus.state_o, obs());
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.state_o, bus.illegal_o, obs()} !== {4'd0, 1'b0, 18'd0}) begin
            errors++; $display("FAIL rstmid_after: got st=%0d ill=%b ctrl=%05h want st=0 ill=0 ctrl=00000",
                               bus.state_o, bus.illegal_o, obs());
        end
        checks++;
        if ({bus.cyc_cnt_o, bus.instr_cnt_o, bus.wait_cnt_o} !== 96'd0) begin
            errors++; $display("FAIL rstmid_counters: got %0d/%0d/%0d want 0/0/0",
                               bus.cyc_cnt_o, bus.instr_cnt_o, bus.wait_cnt_o);
        end
        rst = 1'b0; bus.mem_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.state_o, obs()} !== {4'd0, E_FETCH}) begin
            errors++; $display("FAIL rstmid_refetch: got st=%0d ctrl=%05h want st=0 ctrl=%05h",
                               bus.state_o, obs(), E_FETCH);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
